fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory request/acknowledge handshake, and the IF/ID pipeline register.
- Consumes the ID-stage branch decision (comparator output plus branch/jump targets) and redirects the PC after the architectural delay slot.
- Absorbs hazard-unit stalls and variable-latency instruction memory without losing or duplicating instructions.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, imem request/ack handshake and IF/ID register.
// Branch/jump redirects take effect after the delay slot has been delivered.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        id_valid,
  input  logic        id_br,
  input  logic        id_cmpout,
  input  logic [31:0] id_br_target,
  input  logic        id_jmp,
  input  logic [31:0] id_jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc8,
  output logic        if_id_valid
);

  localparam logic ST_FETCH = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  logic        state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_v_q, buf_v_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;

  logic        redir;
  logic [31:0] redir_tgt;
  logic        fetch_ack;
  logic        hold_deliver;
  logic        deliver;
  logic [31:0] deliver_word;
  logic [31:0] next_pc;

  assign redir        = id_valid & ~stall & ((id_br & id_cmpout) | id_jmp);
  assign redir_tgt    = (id_jmp ? id_jmp_target : id_br_target) & ~32'h3;
  assign fetch_ack    = (state_q == ST_FETCH) & imem_ack;
  assign hold_deliver = (state_q == ST_HOLD) & buf_v_q;
  assign deliver      = ~stall & (fetch_ack | hold_deliver);
  assign deliver_word = (state_q == ST_HOLD) ? buf_q : imem_rdata;

  // A pending target always wins: it belongs to a branch older than anything in ID.
  assign next_pc = pend_v_q ? pend_tgt_q :
                   redir    ? redir_tgt  : pc_q + 32'd4;

  // Request is gated by reset so an in-flight fetch is dropped the moment reset asserts.
  assign imem_req    = reset_n & (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc8   = pc8_q;
  assign if_id_valid = valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    buf_d      = buf_q;
    buf_v_d    = buf_v_q;
    instr_d    = instr_q;
    pc8_d      = pc8_q;
    valid_d    = valid_q;

    if (deliver) begin
      pc_d     = next_pc;
      pend_v_d = 1'b0;
    end else if (redir && !pend_v_q) begin
      pend_v_d   = 1'b1;
      pend_tgt_d = redir_tgt;
    end

    if (!stall) begin
      if (deliver) begin
        instr_d = deliver_word;
        pc8_d   = pc_q + 32'd8;
        valid_d = 1'b1;
      end else begin
        instr_d = 32'd0;
        pc8_d   = 32'd0;
        valid_d = 1'b0;
      end
    end

    // An ack under stall is parked so the word is neither lost nor refetched.
    case (state_q)
      ST_FETCH: begin
        if (imem_ack && stall) begin
          buf_d   = imem_rdata;
          buf_v_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      default: begin
        if (!stall) begin
          buf_v_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      pend_v_q   <= 1'b0;
      pend_tgt_q <= 32'd0;
      buf_q      <= 32'd0;
      buf_v_q    <= 1'b0;
      instr_q    <= 32'd0;
      pc8_q      <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
      buf_q      <= buf_d;
      buf_v_q    <= buf_v_d;
      instr_q    <= instr_d;
      pc8_q      <= pc8_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async reset sequence, then random
// stall/ack/redirect traffic against an instruction-stream reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        id_valid;
  logic        id_br;
  logic        id_cmpout;
  logic [31:0] id_br_target;
  logic        id_jmp;
  logic [31:0] id_jmp_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc8;
  logic        if_id_valid;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .id_valid     (id_valid),
    .id_br        (id_br),
    .id_cmpout    (id_cmpout),
    .id_br_target (id_br_target),
    .id_jmp       (id_jmp),
    .id_jmp_target(id_jmp_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_id_instr  (if_id_instr),
    .if_id_pc8    (if_id_pc8),
    .if_id_valid  (if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h2400_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ack_ok, input logic br, input logic cmp,
                       input logic [31:0] brt, input logic jmp, input logic [31:0] jt);
    stall         = st;
    id_valid      = if_id_valid;
    id_br         = br;
    id_cmpout     = cmp;
    id_br_target  = brt;
    id_jmp        = jmp;
    id_jmp_target = jt;
    imem_ack      = ack_ok & imem_req;
    imem_rdata    = imem_ack ? mem_word(imem_addr) : $urandom;
  endtask

  typedef struct {
    logic        stall;
    logic        ack;
    logic        br;
    logic        cmp;
    logic        jmp;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc8;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic ak, input logic br, input logic cmp,
                              input logic jmp, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = st; v.ack = ak; v.br = br; v.cmp = cmp; v.jmp = jmp;
    v.exp_req = er; v.exp_addr = ea; v.exp_v = ev; v.exp_pc8 = ep;
    return v;
  endfunction

  vec_t vecs[20];

  // Reference model state: accepted-but-undelivered fetches, model IF/ID, redirect record.
  logic [31:0] q[$];
  logic        mv;
  logic [31:0] mpc8, minstr;
  logic        acc_seen;
  logic [31:0] last_acc;
  logic        rd_v;
  logic [31:0] rd_ds, rd_tgt, last_ds;

  initial begin
    logic        st, ak, br, cmp, jmp, use_rd, exp_req, taken;
    logic [31:0] brt, jt, exp_addr, a;

    // Branch target 3101 / jump target 3202 also exercise the forced-zero low bits.
    vecs[0]  = mk(0, 1, 0, 0, 0, 1, 32'h3000, 1, 32'h3008);
    vecs[1]  = mk(0, 1, 0, 0, 0, 1, 32'h3004, 1, 32'h300C);
    vecs[2]  = mk(0, 1, 1, 1, 0, 1, 32'h3008, 1, 32'h3010);
    vecs[3]  = mk(0, 1, 0, 0, 0, 1, 32'h3100, 1, 32'h3108);
    vecs[4]  = mk(0, 1, 1, 0, 0, 1, 32'h3104, 1, 32'h310C);
    vecs[5]  = mk(0, 1, 0, 0, 0, 1, 32'h3108, 1, 32'h3110);
    vecs[6]  = mk(0, 0, 0, 0, 1, 1, 32'h310C, 0, 32'h0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 32'h310C, 0, 32'h0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 32'h310C, 0, 32'h0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 1, 32'h310C, 1, 32'h3114);
    vecs[10] = mk(0, 1, 0, 0, 0, 1, 32'h3200, 1, 32'h3208);
    vecs[11] = mk(1, 1, 1, 1, 0, 1, 32'h3204, 1, 32'h3208);
    vecs[12] = mk(1, 0, 1, 1, 0, 0, 32'h0,    1, 32'h3208);
    vecs[13] = mk(0, 0, 1, 1, 0, 0, 32'h0,    1, 32'h320C);
    vecs[14] = mk(0, 1, 0, 0, 0, 1, 32'h3100, 1, 32'h3108);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 32'h3104, 0, 32'h0);
    vecs[16] = mk(0, 1, 0, 0, 1, 1, 32'h3104, 1, 32'h310C);
    vecs[17] = mk(0, 1, 0, 0, 0, 1, 32'h3108, 1, 32'h3110);
    vecs[18] = mk(1, 0, 0, 0, 0, 1, 32'h310C, 1, 32'h3110);
    vecs[19] = mk(0, 1, 0, 0, 0, 1, 32'h310C, 1, 32'h3114);

    // Reset held 3 cycles with a stray ack that must be ignored.
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    imem_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_req",   {31'd0, imem_req},    32'd0);
      chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
      chk("rst_instr", if_id_instr, 32'd0);
      chk("rst_pc8",   if_id_pc8,   32'd0);
      chk("rst_addr",  imem_addr,   RESET_PC);
    end
    reset_n  = 1'b1;
    imem_ack = 1'b0;
    #1;

    for (int i = 0; i < 20; i++) begin
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      drive(vecs[i].stall, vecs[i].ack, vecs[i].br, vecs[i].cmp, 32'h3101,
            vecs[i].jmp, 32'h3202);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].exp_v});
      chk($sformatf("vec%0d_pc8", i), if_id_pc8, vecs[i].exp_pc8);
      chk($sformatf("vec%0d_instr", i), if_id_instr,
          vecs[i].exp_v ? mem_word(vecs[i].exp_pc8 - 32'd8) : 32'd0);
    end

    // Async reset while a fetch is outstanding: effect must be visible before any edge.
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    #2;
    chk("pre_areset_req", {31'd0, imem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("areset_req",   {31'd0, imem_req},    32'd0);
    chk("areset_valid", {31'd0, if_id_valid}, 32'd0);
    chk("areset_addr",  imem_addr, RESET_PC);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("areset_ack_ignored", {31'd0, if_id_valid}, 32'd0);
    chk("areset_hold_addr", imem_addr, RESET_PC);
    imem_ack = 1'b0;
    reset_n  = 1'b1;
    #1;

    // Random phase.
    q.delete();
    mv = 1'b0; mpc8 = 32'd0; minstr = 32'd0;
    acc_seen = 1'b0; last_acc = 32'd0;
    rd_v = 1'b0; rd_ds = 32'd0; rd_tgt = 32'd0; last_ds = 32'hFFFF_FFFF;

    for (int n = 0; n < 3000; n++) begin
      chk("rnd_valid", {31'd0, if_id_valid}, {31'd0, mv});
      chk("rnd_pc8",   if_id_pc8,   mpc8);
      chk("rnd_instr", if_id_instr, minstr);
      exp_req = (q.size() == 0);
      chk("rnd_req", {31'd0, imem_req}, {31'd0, exp_req});
      use_rd   = acc_seen && rd_v && (rd_ds == last_acc);
      exp_addr = !acc_seen ? RESET_PC : (use_rd ? rd_tgt : last_acc + 32'd4);
      if (imem_req && exp_req)
        chk("rnd_addr", imem_addr, exp_addr);

      st  = ($urandom % 4) == 0;
      ak  = ($urandom % 3) != 0;
      cmp = $urandom % 2;
      br  = 1'b0;
      jmp = 1'b0;
      if (mv && !rd_v && (mpc8 - 32'd8 != last_ds)) begin
        br  = ($urandom % 4) == 0;
        jmp = !br && (($urandom % 6) == 0);
      end
      brt = 32'h3000 + ($urandom_range(0, 1023) << 2) + ($urandom % 4);
      jt  = 32'h3000 + ($urandom_range(0, 1023) << 2) + ($urandom % 4);
      drive(st, ak, br, cmp, brt, jmp, jt);

      taken = id_valid && !st && ((br && cmp) || jmp);
      if (imem_req && imem_ack) begin
        if (use_rd) rd_v = 1'b0;
        acc_seen = 1'b1;
        last_acc = exp_addr;
        q.push_back(exp_addr);
      end
      if (taken) begin
        rd_v    = 1'b1;
        rd_ds   = mpc8 - 32'd4;
        rd_tgt  = (jmp ? jt : brt) & ~32'h3;
        last_ds = mpc8 - 32'd4;
      end
      if (!st) begin
        if (q.size() > 0) begin
          a      = q.pop_front();
          mv     = 1'b1;
          mpc8   = a + 32'd8;
          minstr = mem_word(a);
        end else begin
          mv = 1'b0; mpc8 = 32'd0; minstr = 32'd0;
        end
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
